// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 stream arbiter: holds a grant for a whole packet or MAX_BEATS beats, then alternates.
// Grant decision is registered (1 cycle), the datapath is combinational; Y_ready stalls the granted side only.
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              A_valid,
  input  logic [DATA_W-1:0] A_data,
  input  logic              A_last,
  output logic              A_ready,
  input  logic              B_valid,
  input  logic [DATA_W-1:0] B_data,
  input  logic              B_last,
  output logic              B_ready,
  output logic              Y_valid,
  output logic [DATA_W-1:0] Y_data,
  output logic              Y_last,
  input  logic              Y_ready,
  output logic              Select,
  output logic              Busy
);

  localparam int CNT_W = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MAX_BEATS < 1) ? 0 : MAX_BEATS - 1);
  localparam logic LIMIT_EN = (MAX_BEATS > 0);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t           state_q, state_d;
  logic             ptr_a_q, ptr_a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             select_q, busy_q;
  logic             beat, cur_last, release_now;

  function automatic state_t decide(input logic ptr_a, input logic av, input logic bv);
    if (av && bv) return ptr_a ? GRANT_A : GRANT_B;
    if (av)       return GRANT_A;
    if (bv)       return GRANT_B;
    return IDLE;
  endfunction

  always_comb begin
    beat     = 1'b0;
    cur_last = 1'b0;
    case (state_q)
      GRANT_A: begin beat = A_valid & Y_ready; cur_last = A_last; end
      GRANT_B: begin beat = B_valid & Y_ready; cur_last = B_last; end
      default: begin beat = 1'b0; cur_last = 1'b0; end
    endcase
    // Last beat and beat limit on the same cycle collapse into one release.
    release_now = beat & (cur_last | (LIMIT_EN & (cnt_q == LIMIT)));
  end

  always_comb begin
    state_d = state_q;
    ptr_a_d = ptr_a_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = decide(ptr_a_q, A_valid, B_valid);
      cnt_d   = '0;
    end else if (release_now) begin
      ptr_a_d = (state_q != GRANT_A);
      state_d = decide(ptr_a_d, A_valid, B_valid);
      cnt_d   = '0;
    end else if (beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_a_q  <= 1'b1;
      cnt_q    <= '0;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_a_q  <= ptr_a_d;
      cnt_q    <= cnt_d;
      select_q <= (state_d == GRANT_A);
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    Y_valid = 1'b0;
    Y_data  = '0;
    Y_last  = 1'b0;
    A_ready = 1'b0;
    B_ready = 1'b0;
    case (state_q)
      GRANT_A: begin
        Y_valid = A_valid;
        Y_last  = A_valid & A_last;
        Y_data  = A_valid ? A_data : '0;
        A_ready = Y_ready;
      end
      GRANT_B: begin
        Y_valid = B_valid;
        Y_last  = B_valid & B_last;
        Y_data  = B_valid ? B_data : '0;
        B_ready = Y_ready;
      end
      default: ;
    endcase
  end

  assign Select = select_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: three instances (MAX_BEATS 16, 4, 0) share one stimulus set.
module tb_mux2_rr_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, y_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;

  logic       a_ready [3];
  logic       b_ready [3];
  logic       y_valid [3];
  logic [7:0] y_data  [3];
  logic       y_last  [3];
  logic       sel     [3];
  logic       busy    [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(16)) dut16 (
    .Clk(Clk), .Reset(Reset),
    .A_valid(a_valid), .A_data(a_data), .A_last(a_last), .A_ready(a_ready[0]),
    .B_valid(b_valid), .B_data(b_data), .B_last(b_last), .B_ready(b_ready[0]),
    .Y_valid(y_valid[0]), .Y_data(y_data[0]), .Y_last(y_last[0]), .Y_ready(y_ready),
    .Select(sel[0]), .Busy(busy[0]));

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) dut4 (
    .Clk(Clk), .Reset(Reset),
    .A_valid(a_valid), .A_data(a_data), .A_last(a_last), .A_ready(a_ready[1]),
    .B_valid(b_valid), .B_data(b_data), .B_last(b_last), .B_ready(b_ready[1]),
    .Y_valid(y_valid[1]), .Y_data(y_data[1]), .Y_last(y_last[1]), .Y_ready(y_ready),
    .Select(sel[1]), .Busy(busy[1]));

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(0)) dut0 (
    .Clk(Clk), .Reset(Reset),
    .A_valid(a_valid), .A_data(a_data), .A_last(a_last), .A_ready(a_ready[2]),
    .B_valid(b_valid), .B_data(b_data), .B_last(b_last), .B_ready(b_ready[2]),
    .Y_valid(y_valid[2]), .Y_data(y_data[2]), .Y_last(y_last[2]), .Y_ready(y_ready),
    .Select(sel[2]), .Busy(busy[2]));

  typedef struct {
    int         inst;
    bit         rst;
    logic       av; logic [7:0] ad; logic al;
    logic       bv; logic [7:0] bd; logic bl;
    logic       yr;
    logic [13:0] exp;  // {Y_valid, Y_data, Y_last, A_ready, B_ready, Select, Busy}
  } vec_t;

  vec_t vq[$];

  function automatic logic [13:0] outs(input int k);
    return {y_valid[k], y_data[k], y_last[k], a_ready[k], b_ready[k], sel[k], busy[k]};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,data,last,ar,br,sel,busy}=%b_%h_%b%b%b%b%b required %b_%h_%b%b%b%b%b",
               name, act[13], act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[13], exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input int inst, input bit rst,
                     input logic av, input logic [7:0] ad, input logic al,
                     input logic bv, input logic [7:0] bd, input logic bl, input logic yr,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic ear, input logic ebr, input logic esel, input logic ebusy);
    vec_t v;
    v.inst = inst; v.rst = rst;
    v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr;
    v.exp = {ev, ed, el, ear, ebr, esel, ebusy};
    vq.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl, input logic yr);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl; y_ready = yr;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
    Reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_state_inst%0d", k), outs(k), 14'h0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    // Single A packet; A is still valid on its last beat, so it is re-granted and then waits.
    add(0,1, 1,8'h11,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0,0,0);
    add(0,0, 1,8'h11,0, 0,8'h00,0, 1,  1,8'h11,0, 1,0,1,1);
    add(0,0, 1,8'h22,0, 0,8'h00,0, 1,  1,8'h22,0, 1,0,1,1);
    add(0,0, 1,8'h33,1, 0,8'h00,0, 1,  1,8'h33,1, 1,0,1,1);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 1,0,1,1);
    // Contention with continuous 2-beat packets: A, B, A, B with no bubble.
    add(0,1, 1,8'hA1,0, 1,8'hB1,0, 1,  0,8'h00,0, 0,0,0,0);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 1,  1,8'hA1,0, 1,0,1,1);
    add(0,0, 1,8'hA2,1, 1,8'hB1,0, 1,  1,8'hA2,1, 1,0,1,1);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 1,  1,8'hB1,0, 0,1,0,1);
    add(0,0, 1,8'hA1,0, 1,8'hB2,1, 1,  1,8'hB2,1, 0,1,0,1);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 1,  1,8'hA1,0, 1,0,1,1);
    add(0,0, 1,8'hA2,1, 1,8'hB1,0, 1,  1,8'hA2,1, 1,0,1,1);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 1,  1,8'hB1,0, 0,1,0,1);
    // MAX_BEATS=4: 5 stall cycles must not count, then 4 beats force a split to B.
    add(1,1, 1,8'h51,0, 1,8'hB1,0, 0,  0,8'h00,0, 0,0,0,0);
    for (int s = 0; s < 5; s++)
      add(1,0, 1,8'h51,0, 1,8'hB1,0, 0,  1,8'h51,0, 0,0,1,1);
    add(1,0, 1,8'h51,0, 1,8'hB1,0, 1,  1,8'h51,0, 1,0,1,1);
    add(1,0, 1,8'h52,0, 1,8'hB1,0, 1,  1,8'h52,0, 1,0,1,1);
    add(1,0, 1,8'h53,0, 1,8'hB1,0, 1,  1,8'h53,0, 1,0,1,1);
    add(1,0, 1,8'h54,0, 1,8'hB1,0, 1,  1,8'h54,0, 1,0,1,1);
    add(1,0, 1,8'h55,0, 1,8'hB1,0, 1,  1,8'hB1,0, 0,1,0,1);
    add(1,0, 1,8'h55,0, 1,8'hB2,1, 1,  1,8'hB2,1, 0,1,0,1);
    add(1,0, 1,8'h55,0, 0,8'h00,0, 1,  1,8'h55,0, 1,0,1,1);
    add(1,0, 1,8'h56,1, 0,8'h00,0, 1,  1,8'h56,1, 1,0,1,1);
    add(1,0, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 1,0,1,1);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      @(negedge Clk);
      drive(vq[i].av, vq[i].ad, vq[i].al, vq[i].bv, vq[i].bd, vq[i].bl, vq[i].yr);
      #1;
      chk($sformatf("vec%0d", i), outs(vq[i].inst), vq[i].exp);
      chk($sformatf("vec%0d_ready_exclusive", i),
          {13'h0, a_ready[vq[i].inst] & b_ready[vq[i].inst]}, 14'h0);
    end

    // Reset mid-packet: pointer has moved to B, reset must bring it back to A.
    do_reset();
    @(negedge Clk); drive(1, 8'h61, 1, 0, 8'h00, 0, 1); #1;
    chk("rst_mid_idle", outs(0), {1'b0, 8'h00, 1'b0, 4'b0000});
    @(negedge Clk); drive(1, 8'h61, 1, 1, 8'hC1, 0, 1); #1;
    chk("rst_mid_a_last", outs(0), {1'b1, 8'h61, 1'b1, 4'b1011});
    @(negedge Clk); drive(0, 8'h00, 0, 1, 8'hC1, 0, 1); #1;
    chk("rst_mid_b_beat1", outs(0), {1'b1, 8'hC1, 1'b0, 4'b0101});
    @(negedge Clk); drive(0, 8'h00, 0, 1, 8'hC2, 0, 1); #1;
    chk("rst_mid_b_beat2", outs(0), {1'b1, 8'hC2, 1'b0, 4'b0101});
    Reset = 1'b1; #1;
    chk("rst_mid_async_clear", outs(0), 14'h0);
    @(negedge Clk); Reset = 1'b0; drive(1, 8'h71, 0, 1, 8'hC3, 0, 1); #1;
    chk("rst_mid_after_idle", outs(0), 14'h0);
    @(negedge Clk); #1;
    chk("rst_mid_a_first", outs(0), {1'b1, 8'h71, 1'b0, 4'b1011});

    // MAX_BEATS=0: a 40-beat A packet is never split.
    do_reset();
    @(negedge Clk); drive(1, 8'h00, 0, 1, 8'hBB, 0, 1); #1;
    chk("nolimit_idle", outs(2), 14'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk); drive(1, 8'(i), (i == 39), 1, 8'hBB, 0, 1); #1;
      chk($sformatf("nolimit_beat%0d", i), outs(2), {1'b1, 8'(i), (i == 39), 4'b1011});
    end
    @(negedge Clk); drive(0, 8'h00, 0, 1, 8'hBB, 0, 1); #1;
    chk("nolimit_switch_b", outs(2), {1'b1, 8'hBB, 1'b0, 4'b0101});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
